// File: rtl/calc_ctrl.sv
// Control FSM for the 4-bit calculator datapath: operand load, unit
// dispatch, completion wait with watchdog, result write and display select.
module calc_ctrl #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic [2:0] op,
  input  logic       y_zero,
  input  logic       Done_Calc,
  input  logic       Done_DIV,
  output logic       EN_X,
  output logic       EN_Y,
  output logic       Go_Calc,
  output logic       Go_DIV,
  output logic [1:0] Op_Calc,
  output logic       Sel_H,
  output logic [1:0] Sel_L,
  output logic       En_Out_H,
  output logic       En_Out_L,
  output logic [1:0] Sel_out,
  output logic       done,
  output logic       err,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LOAD      = 4'd1,
    S_DISPATCH  = 4'd2,
    S_CALC_GO   = 4'd3,
    S_CALC_WAIT = 4'd4,
    S_DIV_GO    = 4'd5,
    S_DIV_WAIT  = 4'd6,
    S_WRITE     = 4'd7,
    S_DONE      = 4'd8,
    S_ERR       = 4'd9
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  state_t           state_n;
  logic [2:0]       op_r;
  logic [2:0]       op_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [1:0]       sel_l_n;

  always_comb begin
    state_n = S_IDLE;
    op_n    = op_r;
    cnt_n   = '0;
    case (state)
      S_IDLE: begin
        if (go) begin
          state_n = S_LOAD;
          op_n    = op;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_LOAD: state_n = S_DISPATCH;
      S_DISPATCH: begin
        unique case (1'b1)
          (op_r[2:1] == 2'b11) ||
          ((op_r == 3'b101) && y_zero):
            state_n = S_ERR;
          !op_r[2]:
            state_n = S_CALC_GO;
          (op_r == 3'b100):
            state_n = S_WRITE;
          default:
            state_n = S_DIV_GO;
        endcase
      end
      S_CALC_GO: begin
        state_n = Done_Calc ? S_WRITE : S_CALC_WAIT;
      end
      S_CALC_WAIT: begin
        cnt_n = cnt + 1'b1;
        if (Done_Calc)
          state_n = S_WRITE;
        else if (cnt == CNT_LAST)
          state_n = S_ERR;
        else
          state_n = S_CALC_WAIT;
      end
      S_DIV_GO: begin
        state_n = Done_DIV ? S_WRITE : S_DIV_WAIT;
      end
      S_DIV_WAIT: begin
        cnt_n = cnt + 1'b1;
        if (Done_DIV)
          state_n = S_WRITE;
        else if (cnt == CNT_LAST)
          state_n = S_ERR;
        else
          state_n = S_DIV_WAIT;
      end
      S_WRITE: state_n = S_DONE;
      S_DONE:  state_n = go ? S_DONE : S_IDLE;
      S_ERR:   state_n = go ? S_ERR : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Low result source: ALU, product low or quotient
  always_comb begin
    sel_l_n = 2'd0;
    if (state_n == S_WRITE) begin
      unique case (1'b1)
        !op_n[2]:          sel_l_n = 2'd1;
        (op_n == 3'b100):  sel_l_n = 2'd2;
        default:           sel_l_n = 2'd3;
      endcase
    end
  end

  // Outputs are registered from the next state so they track state exactly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      op_r     <= '0;
      cnt      <= '0;
      EN_X     <= 1'b0;
      EN_Y     <= 1'b0;
      Go_Calc  <= 1'b0;
      Go_DIV   <= 1'b0;
      Op_Calc  <= '0;
      Sel_H    <= 1'b0;
      Sel_L    <= '0;
      En_Out_H <= 1'b0;
      En_Out_L <= 1'b0;
      Sel_out  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      state_o  <= '0;
    end else begin
      state    <= state_n;
      op_r     <= op_n;
      cnt      <= cnt_n;
      EN_X     <= (state_n == S_LOAD);
      EN_Y     <= (state_n == S_LOAD);
      Go_Calc  <= (state_n == S_CALC_GO);
      Go_DIV   <= (state_n == S_DIV_GO);
      Op_Calc  <= op_n[1:0];
      Sel_H    <= (state_n == S_WRITE) && (op_n == 3'b101);
      Sel_L    <= sel_l_n;
      En_Out_H <= (state_n == S_WRITE);
      En_Out_L <= (state_n == S_WRITE);
      Sel_out  <= (state_n == S_DONE) ? 2'd1 : 2'd0;
      done     <= (state_n == S_DONE);
      err      <= (state_n == S_ERR);
      state_o  <= state_n;
    end
  end

endmodule

// File: tb/tb_calc_ctrl.sv
// Scoreboard bench for calc_ctrl: a reference model predicts latency,
// pulse counts and result selects for each run.
module tb_calc_ctrl;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic       go;
  logic [2:0] op;
  logic       y_zero;
  logic       Done_Calc;
  logic       Done_DIV;
  logic       EN_X, EN_Y, Go_Calc, Go_DIV;
  logic [1:0] Op_Calc;
  logic       Sel_H;
  logic [1:0] Sel_L;
  logic       En_Out_H, En_Out_L;
  logic [1:0] Sel_out;
  logic       done, err;
  logic [3:0] state_o;

  calc_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .go(go), .op(op), .y_zero(y_zero),
    .Done_Calc(Done_Calc), .Done_DIV(Done_DIV),
    .EN_X(EN_X), .EN_Y(EN_Y), .Go_Calc(Go_Calc), .Go_DIV(Go_DIV),
    .Op_Calc(Op_Calc), .Sel_H(Sel_H), .Sel_L(Sel_L),
    .En_Out_H(En_Out_H), .En_Out_L(En_Out_L), .Sel_out(Sel_out),
    .done(done), .err(err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    bit is_err;
    int lat;
    int sel_l;
    int sel_h;
    int sel_out;
    int n_calc;
    int n_div;
    int n_write;
  } exp_t;

  exp_t sb[$];

  // k: cycles after the Go pulse at which the unit answers (<0: never)
  function automatic exp_t model(input logic [2:0] o, input bit yz,
                                 input int k);
    exp_t e;
    e = '{default: 0};
    if (o[2:1] == 2'b11 || (o == 3'b101 && yz)) begin
      e.is_err = 1;
      e.lat    = 3;
    end else if (o == 3'b100) begin
      e.lat = 4; e.sel_l = 2; e.n_write = 1; e.sel_out = 1;
    end else begin
      if (o == 3'b101) begin
        e.n_div = 1; e.sel_l = 3; e.sel_h = 1;
      end else begin
        e.n_calc = 1; e.sel_l = 1;
      end
      if (k >= 0 && k <= TO) begin
        e.lat = 5 + k; e.n_write = 1; e.sel_out = 1;
      end else begin
        e.is_err = 1; e.lat = 4 + TO; e.sel_l = 0; e.sel_h = 0;
      end
    end
    return e;
  endfunction

  function automatic logic [18:0] outs();
    return {EN_X, EN_Y, Go_Calc, Go_DIV, Op_Calc, Sel_H, Sel_L,
            En_Out_H, En_Out_L, Sel_out, done, err, state_o};
  endfunction

  task automatic run(input logic [2:0] o, input bit yz, input int k,
                     input string tag);
    exp_t e;
    int c, gseen, n_ld, n_c, n_d, n_w, wl, wh;
    bit gdiv;
    @(negedge clk);
    op = o; y_zero = yz; go = 1'b1;
    sb.push_back(model(o, yz, k));
    c = 0; gseen = -1; gdiv = 0;
    n_ld = 0; n_c = 0; n_d = 0; n_w = 0; wl = 0; wh = 0;
    while (c < 60) begin
      @(negedge clk);
      c++;
      if (c == 1) op = ~o;
      if (EN_X && EN_Y) n_ld++;
      if (Go_Calc) begin n_c++; gseen = c; gdiv = 0; end
      if (Go_DIV) begin n_d++; gseen = c; gdiv = 1; end
      if (En_Out_H && En_Out_L) begin n_w++; wl = Sel_L; wh = Sel_H; end
      if (done || err) break;
      Done_Calc = !gdiv && k >= 0 && gseen >= 0 && c == gseen + k;
      Done_DIV  =  gdiv && k >= 0 && gseen >= 0 && c == gseen + k;
    end
    Done_Calc = 1'b0;
    Done_DIV  = 1'b0;
    e = sb.pop_front();
    check({tag, ".lat"},    c, e.lat);
    check({tag, ".err"},    err, e.is_err);
    check({tag, ".done"},   done, !e.is_err);
    check({tag, ".selout"}, Sel_out, e.sel_out);
    check({tag, ".sel_l"},  wl, e.sel_l);
    check({tag, ".sel_h"},  wh, e.sel_h);
    check({tag, ".ncalc"},  n_c, e.n_calc);
    check({tag, ".ndiv"},   n_d, e.n_div);
    check({tag, ".nwrite"}, n_w, e.n_write);
    check({tag, ".nload"},  n_ld, 1);
    check({tag, ".opcalc"}, Op_Calc, o[1:0]);
    repeat (3) @(negedge clk);
    check({tag, ".hold"}, {done, err, EN_X, Go_Calc, Go_DIV},
          e.is_err ? 5'b01000 : 5'b10000);
    go = 1'b0;
    @(negedge clk);
    check({tag, ".idle"}, {done, err, state_o}, 6'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int w;
    reset = 1'b1; go = 1'b0; op = '0; y_zero = 1'b0;
    Done_Calc = 1'b0; Done_DIV = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.outs", outs(), 19'd0);
    reset = 1'b0;

    run(3'b000, 0, 2,  "add");
    run(3'b100, 0, 0,  "mul");
    run(3'b101, 0, 4,  "div");
    run(3'b101, 1, 0,  "divz");
    run(3'b011, 0, -1, "tmo");
    run(3'b011, 0, TO, "tmo_edge");
    run(3'b001, 0, 0,  "sub_fast");
    run(3'b010, 0, 1,  "and");
    run(3'b111, 0, 0,  "ill7");
    run(3'b101, 0, 0,  "div_fast");
    for (int i = 0; i < 6; i++)
      run(3'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
          int'($urandom_range(0, TO + 1)), $sformatf("rnd%0d", i));

    // Reset in the middle of a divide wait
    @(negedge clk);
    op = 3'b101; y_zero = 1'b0; go = 1'b1;
    w = 0;
    while (!Go_DIV && w < 20) begin @(negedge clk); w++; end
    check("rst.godiv_seen", Go_DIV, 1'b1);
    repeat (2) @(negedge clk);
    check("rst.in_wait", state_o, 4'd6);
    #2 reset = 1'b1;
    #1 check("rst.async", outs(), 19'd0);
    go = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    Done_DIV = 1'b1;
    @(negedge clk);
    Done_DIV = 1'b0;
    w = 0;
    repeat (4) begin
      @(negedge clk);
      if (Go_DIV || Go_Calc || state_o != 4'd0) w++;
    end
    check("rst.stay_idle", w, 0);
    check("rst.outs", outs(), 19'd0);

    run(3'b110, 0, 0, "ill6");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_ctrl.md
Name: calc_ctrl

Overview:
- Control unit that sits directly upstream of the 4-bit calculator datapath and drives all of its control inputs.
- On a start request it:
  - loads operands x/y;
  - dispatches the selected operation to the small ALU, the combinational multiplier, or the sequential divider;
  - waits on their done flags;
  - writes the result registers and selects the display output.
- Adds divide-by-zero and watchdog-timeout error handling.

Parameters:
TIMEOUT_CYCLES, 15, max cycles spent in a wait state before ERR (1..255)
CNT_W, 8, width of watchdog counter; must hold TIMEOUT_CYCLES

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
go  input  1  start request, level-sensitive
op  input  3  000 add, 001 sub, 010 and, 011 xor, 100 mul, 101 div, 110/111 illegal
y_zero  input  1  high when the datapath's registered y equals 0
Done_Calc  input  1  small-ALU completion flag
Done_DIV  input  1  divider completion flag
EN_X  output  1  load x operand register
EN_Y  output  1  load y operand register
Go_Calc  output  1  one-cycle start pulse to small ALU
Go_DIV  output  1  one-cycle start pulse to divider
Op_Calc  output  2  ALU op = op_r[1:0]
Sel_H  output  1  0 product high, 1 remainder
Sel_L  output  2  0 zero, 1 ALU result, 2 product low, 3 quotient
En_Out_H  output  1  load result high register
En_Out_L  output  1  load result low register
Sel_out  output  2  0 zero, 1 result, 2 x, 3 y
done  output  1  result valid
err  output  1  error (illegal op, divide by zero, timeout)
state_o  output  4  current state encoding, debug

Behaviour:
- Clock, reset and state register:
  - One clock domain.
  - reset asynchronous, active-high.
  - Reset forces state=IDLE, op_r=0, watchdog counter=0 and every output to 0.
- Output decoding:
  - All outputs are Moore-decoded from the state register and op_r; no output depends combinationally on go.
  - Op_Calc = op_r[1:0] in every state.
- op capture: op_r captures op on the clock edge that leaves IDLE; op changes afterwards are ignored until the next run.
- IDLE: Sel_out=0. go=1 -> LOAD.
- LOAD: EN_X=EN_Y=1 for exactly one cycle -> DISPATCH.
- DISPATCH (registered y now valid):
  - op_r 110/111 -> ERR.
  - op_r 0xx -> CALC_GO.
  - 100 -> WRITE.
  - 101 with y_zero=1 -> ERR.
  - 101 with y_zero=0 -> DIV_GO.
- CALC_GO: Go_Calc=1 for one cycle; counter cleared -> CALC_WAIT, or WRITE if Done_Calc=1 this cycle.
- CALC_WAIT: Go_Calc=0; counter increments each cycle.
  - Done_Calc=1 -> WRITE.
  - Else counter == TIMEOUT_CYCLES-1 -> ERR.
  - Done on the same cycle as expiry: done wins.
- DIV_GO / DIV_WAIT: identical to the CALC pair, using Go_DIV and Done_DIV.
- WRITE: En_Out_H=En_Out_L=1 for one cycle -> DONE. Selects by op_r:
  - 0xx: Sel_L=1, Sel_H=0 (high result register is written with product-high; ALU results are 4-bit only).
  - 100: Sel_L=2, Sel_H=0.
  - 101: Sel_L=3, Sel_H=1.
- DONE: done=1, Sel_out=1; hold while go=1; go=0 -> IDLE.
- ERR: err=1, Sel_out=0, no register enables; hold while go=1; go=0 -> IDLE.
- Latency, counted from the edge sampling go=1 in IDLE:
  - mul: done high 4 cycles later.
  - ALU/div: done high at 5 + k cycles, where k = cycles spent in the WAIT state.
- go held high through DONE/ERR does not retrigger; a new run requires go low for at least one cycle.
- Reset asserted mid-run (any state):
  - immediate return to IDLE, outputs 0;
  - no further Go pulses;
  - any late Done_* input is ignored in IDLE.
- Done_* inputs arriving in states other than *_GO/*_WAIT are ignored.
- Unused state encodings -> IDLE on the next edge.

Test Plan:
- op=000, go high, Done_Calc returned 2 cycles after Go_Calc -> EN_X/EN_Y one pulse; Go_Calc one pulse; WRITE with Sel_L=1; done=1 and Sel_out=1 at cycle 7 after go is sampled.
- op=100, go high -> no Go pulses; WRITE with Sel_L=2, Sel_H=0 at cycle 3; done at cycle 4.
- op=101, y_zero=0, Done_DIV after 4 wait cycles -> Go_DIV one pulse; WRITE with Sel_L=3, Sel_H=1; done=1.
- op=101, y_zero=1 -> ERR from DISPATCH; err=1, Go_DIV never asserted. Then go=0 -> IDLE and err=0.
- op=011, Done_Calc never returned, TIMEOUT_CYCLES=15 -> ERR exactly 15 cycles after entering CALC_WAIT. Variant with Done_Calc on the 15th cycle -> WRITE, not ERR.
- reset asserted during DIV_WAIT, Done_DIV pulsed afterwards -> outputs 0 asynchronously, state stays IDLE. op=110 on a subsequent go -> ERR.
